// File: rtl/decryptor_pkg.sv
// rtl/decryptor_pkg.sv - shared types, default sizes and key-index helper for message_decryptor
package decryptor_pkg;

    typedef logic [7:0] byte_t;

    localparam int DEF_MSG_LEN = 22;
    localparam int DEF_SEC_LEN = 3;

    // Lane i always uses the same key byte, so this folds to a constant at elaboration.
    function automatic int key_idx(input int i, input int sec_len);
        return i % sec_len;
    endfunction

endpackage

// File: rtl/decrypt_lane.sv
// rtl/decrypt_lane.sv - one byte lane: ciphertext minus key byte, modulo 256
module decrypt_lane
    import decryptor_pkg::*;
(
    input  byte_t cipher,
    input  byte_t key,
    output byte_t plain
);

    assign plain = cipher - key;

endmodule

// File: rtl/message_decryptor.sv
// rtl/message_decryptor.sv - repeating-key parallel message decryptor with one-cycle latency
module message_decryptor
    import decryptor_pkg::*;
#(
    parameter int MSG_LEN = DEF_MSG_LEN,
    parameter int SEC_LEN = DEF_SEC_LEN
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  key_we,
    input  byte_t key_in   [0:SEC_LEN-1],
    input  logic  in_valid,
    input  byte_t text_in  [0:MSG_LEN-1],
    output logic  out_valid,
    output byte_t text_out [0:MSG_LEN-1]
);

    byte_t secret [0:SEC_LEN-1];
    byte_t plain  [0:MSG_LEN-1];

    for (genvar g = 0; g < MSG_LEN; g++) begin : g_lane
        localparam int KI = key_idx(g, SEC_LEN);
        decrypt_lane u_lane (
            .cipher (text_in[g]),
            .key    (secret[KI]),
            .plain  (plain[g])
        );
    end

    // Lanes read the key held before this edge, so a same-edge key load
    // only affects the following message.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            for (int j = 0; j < SEC_LEN; j++) secret[j] <= '0;
            for (int i = 0; i < MSG_LEN; i++) text_out[i] <= '0;
        end else begin
            out_valid <= in_valid;
            if (key_we) begin
                for (int j = 0; j < SEC_LEN; j++) secret[j] <= key_in[j];
            end
            if (in_valid) begin
                for (int i = 0; i < MSG_LEN; i++) text_out[i] <= plain[i];
            end
        end
    end

endmodule

// File: tb/tb_message_decryptor.sv
// tb/tb_message_decryptor.sv - self-checking bench for message_decryptor
module tb_message_decryptor;
    import decryptor_pkg::*;

    localparam int ML = 22;
    localparam int SL = 3;

    logic  clk = 1'b0;
    logic  rst;
    logic  key_we;
    byte_t key_in   [0:SL-1];
    logic  in_valid;
    byte_t text_in  [0:ML-1];
    logic  out_valid;
    byte_t text_out [0:ML-1];

    int checks = 0;
    int errors = 0;

    int m_key   [SL];
    int m_out   [ML];
    int m_valid;
    int saved   [ML];

    message_decryptor #(.MSG_LEN(ML), .SEC_LEN(SL)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_we    (key_we),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .text_in   (text_in),
        .out_valid (out_valid),
        .text_out  (text_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < SL; j++) m_key[j] = 0;
        for (int i = 0; i < ML; i++) m_out[i] = 0;
        m_valid = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        for (int i = 0; i < ML; i++)
            check($sformatf("%s.text_out[%0d]", tag, i), 32'(text_out[i]), 32'(m_out[i]));
    endtask

    // Reference: each plaintext byte is ciphertext minus the repeating key byte, modulo 256.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (in_valid)
                for (int i = 0; i < ML; i++)
                    m_out[i] = (int'(text_in[i]) - m_key[i % SL] + 256) % 256;
            m_valid = in_valid ? 1 : 0;
            if (key_we)
                for (int j = 0; j < SL; j++) m_key[j] = int'(key_in[j]);
        end
        #1;
        check_all(tag);
    endtask

    task automatic randomize_text();
        for (int i = 0; i < ML; i++) text_in[i] = byte_t'($urandom_range(0, 255));
    endtask

    task automatic set_key_kEY();
        key_in[0] = 8'd75;
        key_in[1] = 8'd69;
        key_in[2] = 8'd89;
    endtask

    initial begin
        rst      = 1'b1;
        key_we   = 1'b0;
        in_valid = 1'b0;
        for (int j = 0; j < SL; j++) key_in[j] = '0;
        for (int i = 0; i < ML; i++) text_in[i] = '0;
        model_reset();

        #12;
        rst = 1'b0;
        check_all("reset");
        for (int j = 0; j < SL; j++) check($sformatf("reset.secret[%0d]", j), 32'(dut.secret[j]), 32'd0);

        // Identity key after reset
        randomize_text();
        text_in[0] = 8'd72; text_in[1] = 8'd101; text_in[2] = 8'd108;
        in_valid = 1'b1;
        step("identity");
        check("identity.lane0", 32'(text_out[0]), 32'd72);
        check("identity.lane1", 32'(text_out[1]), 32'd101);
        check("identity.lane2", 32'(text_out[2]), 32'd108);
        in_valid = 1'b0;

        // Load key "KEY"
        set_key_kEY();
        key_we = 1'b1;
        step("keyload");
        key_we = 1'b0;
        check("keyload.secret0", 32'(dut.secret[0]), 32'd75);
        check("keyload.secret2", 32'(dut.secret[2]), 32'd89);

        // Wrap-around of the subtraction
        randomize_text();
        text_in[0] = 8'd44; text_in[1] = 8'd46; text_in[2] = 8'd86; text_in[3] = 8'd63; text_in[21] = 8'd56;
        in_valid = 1'b1;
        step("wrap");
        check("wrap.lane0", 32'(text_out[0]), 32'd225);
        check("wrap.lane1", 32'(text_out[1]), 32'd233);
        check("wrap.lane2", 32'(text_out[2]), 32'd253);
        check("wrap.lane3", 32'(text_out[3]), 32'd244);
        check("wrap.lane21", 32'(text_out[21]), 32'd237);

        // Round trip of encryptor output
        randomize_text();
        text_in[0] = 8'd147; text_in[1] = 8'd170; text_in[2] = 8'd197; text_in[3] = 8'd183;
        step("roundtrip");
        check("roundtrip.lane0", 32'(text_out[0]), 32'd72);
        check("roundtrip.lane1", 32'(text_out[1]), 32'd101);
        check("roundtrip.lane2", 32'(text_out[2]), 32'd108);
        check("roundtrip.lane3", 32'(text_out[3]), 32'd108);

        // Asynchronous reset mid-cycle, with a message pending
        @(posedge clk);
        #3;
        randomize_text();
        in_valid = 1'b1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        for (int j = 0; j < SL; j++) check($sformatf("async_rst.secret[%0d]", j), 32'(dut.secret[j]), 32'd0);
        step("in_reset");
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        step("post_reset");

        // Key load and message on the same edge
        set_key_kEY();
        key_we = 1'b1;
        randomize_text();
        text_in[0] = 8'd147;
        in_valid = 1'b1;
        step("simul_old_key");
        check("simul_old_key.lane0", 32'(text_out[0]), 32'd147);
        key_we = 1'b0;
        randomize_text();
        text_in[0] = 8'd147;
        step("simul_new_key");
        check("simul_new_key.lane0", 32'(text_out[0]), 32'd72);

        // Streaming, then idle hold
        for (int k = 0; k < 3; k++) begin
            randomize_text();
            in_valid = 1'b1;
            step($sformatf("stream%0d", k));
        end
        for (int i = 0; i < ML; i++) saved[i] = m_out[i];
        randomize_text();
        in_valid = 1'b0;
        step("idle");
        check("idle.out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < ML; i++)
            check($sformatf("idle.hold[%0d]", i), 32'(text_out[i]), 32'(saved[i]));

        // Randomized traffic with occasional key changes
        for (int n = 0; n < 200; n++) begin
            randomize_text();
            in_valid = ($urandom_range(0, 1) == 1);
            key_we   = ($urandom_range(0, 7) == 0);
            for (int j = 0; j < SL; j++) key_in[j] = byte_t'($urandom_range(0, 255));
            step($sformatf("rand%0d", n));
        end
        key_we   = 1'b0;
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
